// File: rtl/mgmt_bus_hub.sv
// Management-bus hub: one sequenced transaction from mp_core to a slave.
// Optional reply timeout: define MGMT_HUB_TIMEOUT_EN.
module mgmt_bus_hub #(
  parameter int          NSLV       = 5,
  parameter int          SEL_MSB    = 15,
  parameter int          SEL_LSB    = 12,
  parameter int          TMO_CYCLES = 255,
  parameter logic [31:0] ERR_DATA   = 32'hDEAD_BEEF
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              m_req,
  input  logic [31:0]       m_adr,
  input  logic              m_rwn,
  input  logic [1:0]        m_wen,
  input  logic [31:0]       m_txd,
  output logic              m_ack,
  output logic              m_rxe,
  output logic [31:0]       m_rxd,
  output logic              m_err,
  output logic              busy,
  output logic [NSLV-1:0]   s_req,
  output logic [31:0]       s_adr,
  output logic              s_rwn,
  output logic [1:0]        s_wen,
  output logic [31:0]       s_txd,
  input  logic [NSLV-1:0]   s_ack,
  input  logic [NSLV-1:0]   s_rxe,
  input  logic [32*NSLV-1:0] s_rxd
);

  localparam int SW = SEL_MSB - SEL_LSB + 1;

  if (NSLV < 1 || NSLV > 16 || SW < 1 || TMO_CYCLES < 1) begin : g_bad_cfg
    $error("mgmt_bus_hub: illegal parameter set");
  end

  typedef enum logic [1:0] {
    IDLE,
    ACK_WT,
    RXD_WT,
    ERR
  } state_t;

  state_t          state;
  logic [NSLV-1:0] sel_oh;
  logic [NSLV-1:0] sel_dec;
  logic [NSLV-1:0] live_ack;
  logic [NSLV-1:0] live_rxe;
  logic [SW-1:0]   sel_in;
  logic [31:0]     rxd_sel;
  logic            ack_hit;
  logic            rxe_hit;
  logic            stray;
  logic            drop;

`ifdef MGMT_HUB_TIMEOUT_EN
  localparam int TCW = $clog2(TMO_CYCLES + 1);
  localparam int TW  = (TCW > 8) ? TCW : 8;
  localparam logic [TW-1:0] TMO_LAST = TW'(TMO_CYCLES - 1);
  logic [TW-1:0] timer;
`endif

  assign sel_in = m_adr[SEL_MSB:SEL_LSB];

  // One-hot slave decode; all-zero means unmapped.
  always_comb begin
    sel_dec = '0;
    for (int i = 0; i < NSLV; i++) begin
      sel_dec[i] = (int'(sel_in) == i);
    end
  end

  // Read-data mux driven by the latched slave select.
  always_comb begin
    rxd_sel = '0;
    for (int i = 0; i < NSLV; i++) begin
      if (sel_oh[i]) begin
        rxd_sel = rxd_sel | s_rxd[32*i +: 32];
      end
    end
  end

  // Anything not consumed as a real completion is flagged as stray.
  assign ack_hit  = (state == ACK_WT) && |(s_ack & sel_oh);
  assign rxe_hit  = |(s_rxe & sel_oh) &&
                    ((state == RXD_WT) || (ack_hit && s_rwn));
  assign live_ack = ack_hit ? sel_oh : '0;
  assign live_rxe = rxe_hit ? sel_oh : '0;
  assign stray    = |(s_ack & ~live_ack) || |(s_rxe & ~live_rxe);
  assign drop     = m_req && (state != IDLE);

  // Transaction sequencer with registered outputs.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state  <= IDLE;
      sel_oh <= '0;
      s_req  <= '0;
      s_adr  <= '0;
      s_rwn  <= 1'b0;
      s_wen  <= '0;
      s_txd  <= '0;
      m_ack  <= 1'b0;
      m_rxe  <= 1'b0;
      m_rxd  <= '0;
      m_err  <= 1'b0;
      busy   <= 1'b0;
`ifdef MGMT_HUB_TIMEOUT_EN
      timer  <= '0;
`endif
    end else begin
      s_req <= '0;
      m_ack <= 1'b0;
      m_rxe <= 1'b0;
      m_err <= stray || drop;
      unique case (state)
        IDLE: begin
          if (m_req) begin
            s_adr  <= m_adr;
            s_rwn  <= m_rwn;
            s_wen  <= m_wen;
            s_txd  <= m_txd;
            sel_oh <= sel_dec;
            busy   <= 1'b1;
            if (|sel_dec) begin
              s_req <= sel_dec;
              state <= ACK_WT;
`ifdef MGMT_HUB_TIMEOUT_EN
              timer <= '0;
`endif
            end else begin
              state <= ERR;
            end
          end
        end
        ACK_WT: begin
          if (ack_hit) begin
            m_ack <= 1'b1;
            if (!s_rwn) begin
              state <= IDLE;
              busy  <= 1'b0;
            end else if (rxe_hit) begin
              m_rxe <= 1'b1;
              m_rxd <= rxd_sel;
              state <= IDLE;
              busy  <= 1'b0;
            end else begin
              state <= RXD_WT;
`ifdef MGMT_HUB_TIMEOUT_EN
              timer <= '0;
`endif
            end
          end else begin
`ifdef MGMT_HUB_TIMEOUT_EN
            if (timer == TMO_LAST) begin
              state <= ERR;
            end else begin
              timer <= timer + 1'b1;
            end
`else
            state <= ACK_WT;
`endif
          end
        end
        RXD_WT: begin
          if (rxe_hit) begin
            m_rxe <= 1'b1;
            m_rxd <= rxd_sel;
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
`ifdef MGMT_HUB_TIMEOUT_EN
            if (timer == TMO_LAST) begin
              state <= ERR;
            end else begin
              timer <= timer + 1'b1;
            end
`else
            state <= RXD_WT;
`endif
          end
        end
        ERR: begin
          m_ack <= 1'b1;
          m_err <= 1'b1;
          if (s_rwn) begin
            m_rxe <= 1'b1;
            m_rxd <= ERR_DATA;
          end
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
